// File: rtl/ir_frame_controller.sv
// rtl/ir_frame_controller.sv - NEC-style IR frame decoder with held-frame handshake
module ir_frame_controller #(
    parameter int CLK_PER_US = 50,
    parameter int TIMEOUT_US = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_n,
    input  logic       ack,
    output logic       frame_valid,
    output logic [7:0] address,
    output logic [7:0] command,
    output logic       repeat_pulse,
    output logic       error_pulse,
    output logic       overrun_pulse
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int WW = ($clog2(TIMEOUT_US + 1) > 14) ? $clog2(TIMEOUT_US + 1) : 14;

    typedef enum logic [2:0] {
        IDLE,
        LDR_MARK,
        LDR_SPACE,
        BIT_MARK,
        BIT_SPACE,
        CHECK
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [PW-1:0] pre;
    logic [WW-1:0] width;
    logic [5:0]    bit_cnt;
    logic [31:0]   shift_reg;

    function automatic logic in_range(input logic [WW-1:0] w, input int lo, input int hi);
        return (int'(w) >= lo) && (int'(w) <= hi);
    endfunction

    logic fall;
    logic rise;
    logic tick;
    logic timeout;
    logic ldr_mark_ok;
    logic ldr_space_ok;
    logic rep_space_ok;
    logic short_ok;
    logic long_ok;
    logic frame_ok;

    assign fall         = level_q & ~sync2;
    assign rise         = ~level_q & sync2;
    assign tick         = (pre == PW'(CLK_PER_US - 1));
    assign timeout      = (width == WW'(TIMEOUT_US));
    assign ldr_mark_ok  = in_range(width, 8000, 10000);
    assign ldr_space_ok = in_range(width, 4000, 5000);
    assign rep_space_ok = in_range(width, 2000, 2500);
    assign short_ok     = in_range(width, 400, 720);
    assign long_ok      = in_range(width, 1400, 1900);
    assign frame_ok     = (shift_reg[15:8] == ~shift_reg[7:0]) &&
                          (shift_reg[31:24] == ~shift_reg[23:16]);

    // Idle line is high, so the synchronizer resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1   <= ir_n;
            sync2   <= sync1;
            level_q <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre   <= '0;
            width <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (fall || rise) begin
                width <= '0;
            end else if (tick && !timeout) begin
                width <= width + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            frame_valid   <= 1'b0;
            address       <= '0;
            command       <= '0;
            repeat_pulse  <= 1'b0;
            error_pulse   <= 1'b0;
            overrun_pulse <= 1'b0;
        end else begin
            repeat_pulse  <= 1'b0;
            error_pulse   <= 1'b0;
            overrun_pulse <= 1'b0;
            // A load in CHECK assigns later and therefore wins over ack.
            if (ack) begin
                frame_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= LDR_MARK;
                    end
                end
                LDR_MARK: begin
                    if (rise && ldr_mark_ok) begin
                        state <= LDR_SPACE;
                    end else if (rise || timeout) begin
                        state       <= IDLE;
                        error_pulse <= 1'b1;
                    end
                end
                LDR_SPACE: begin
                    if (fall && ldr_space_ok) begin
                        state   <= BIT_MARK;
                        bit_cnt <= '0;
                    end else if (fall && rep_space_ok) begin
                        state        <= IDLE;
                        repeat_pulse <= 1'b1;
                    end else if (fall || timeout) begin
                        state       <= IDLE;
                        error_pulse <= 1'b1;
                    end
                end
                BIT_MARK: begin
                    if (rise && short_ok) begin
                        state <= BIT_SPACE;
                    end else if (rise || timeout) begin
                        state       <= IDLE;
                        error_pulse <= 1'b1;
                    end
                end
                BIT_SPACE: begin
                    if (fall && (short_ok || long_ok)) begin
                        shift_reg <= {long_ok, shift_reg[31:1]};
                        bit_cnt   <= bit_cnt + 6'd1;
                        state     <= (bit_cnt == 6'd31) ? CHECK : BIT_MARK;
                    end else if (fall || timeout) begin
                        state       <= IDLE;
                        error_pulse <= 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        error_pulse <= 1'b1;
                    end else if (frame_valid) begin
                        overrun_pulse <= 1'b1;
                    end else begin
                        address     <= shift_reg[7:0];
                        command     <= shift_reg[23:16];
                        frame_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_frame_controller.sv
// tb/tb_ir_frame_controller.sv - table-driven scoreboard bench for ir_frame_controller
`timescale 1ns/1ps
module tb_ir_frame_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ir_n = 1'b1;
    logic       ack = 1'b0;
    logic       frame_valid;
    logic [7:0] address;
    logic [7:0] command;
    logic       repeat_pulse;
    logic       error_pulse;
    logic       overrun_pulse;

    always #5 clk = ~clk;

    ir_frame_controller #(.CLK_PER_US(1), .TIMEOUT_US(12000)) dut (
        .clk(clk),
        .reset(reset),
        .ir_n(ir_n),
        .ack(ack),
        .frame_valid(frame_valid),
        .address(address),
        .command(command),
        .repeat_pulse(repeat_pulse),
        .error_pulse(error_pulse),
        .overrun_pulse(overrun_pulse)
    );

    localparam int EV_LOAD = 0;
    localparam int EV_REP  = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_OVR  = 3;

    localparam int K_FRAME     = 0;
    localparam int K_REPEAT    = 1;
    localparam int K_SHORT_LDR = 2;
    localparam int K_BAD_SPACE = 3;
    localparam int K_SHORT_BIT = 4;

    typedef struct {
        int ev;
        logic [7:0] a;
        logic [7:0] c;
    } exp_t;

    typedef struct {
        int          kind;
        logic [31:0] word;
        bit          do_ack;
        int          ev;
        logic [7:0]  ea;
        logic [7:0]  ec;
        bit          efv;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic fv_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse or frame_valid rise pops one expectation.
    always @(negedge clk) begin
        int   npulse;
        int   ev;
        exp_t e;
        npulse = int'(repeat_pulse) + int'(error_pulse) + int'(overrun_pulse);
        if (npulse > 0 || (frame_valid && !fv_q)) begin
            check("pulse_exclusive", (npulse > 1) ? 1 : 0, 0);
            ev = error_pulse ? EV_ERR : overrun_pulse ? EV_OVR : repeat_pulse ? EV_REP : EV_LOAD;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%0d required=none", ev);
            end else begin
                e = sb.pop_front();
                check("event_kind", ev, e.ev);
                if (ev == EV_LOAD) begin
                    check("load_address", address, e.a);
                    check("load_command", command, e.c);
                end
            end
        end
        fv_q = frame_valid;
    end

    task automatic hold(input logic v, input int n);
        ir_n = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, 450);
            hold(1'b1, w[i] ? 1450 : 450);
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        hold(1'b0, 8100);
        hold(1'b1, 4100);
        send_bits(w, 32);
        hold(1'b0, 450);
        hold(1'b1, 200);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
        hold(1'b1, 50);
    endtask

    task automatic expect_ev(input int ev, input logic [7:0] a, input logic [7:0] c);
        exp_t e;
        e.ev = ev;
        e.a  = a;
        e.c  = c;
        sb.push_back(e);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        check("fv_before_ack", frame_valid, 1);
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ack_clears_fv", frame_valid, 0);
    endtask

    initial begin
        #6_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   n;
        tbl[0] = '{K_FRAME,     32'hE41BFB04, 1'b0, EV_LOAD, 8'h04, 8'h1B, 1'b1};
        tbl[1] = '{K_REPEAT,    32'h0,        1'b0, EV_REP,  8'h04, 8'h1B, 1'b1};
        tbl[2] = '{K_SHORT_LDR, 32'h0,        1'b0, EV_ERR,  8'h04, 8'h1B, 1'b1};
        tbl[3] = '{K_FRAME,     32'h3CC3AA55, 1'b1, EV_OVR,  8'h04, 8'h1B, 1'b1};
        tbl[4] = '{K_FRAME,     32'hE51BFB04, 1'b0, EV_ERR,  8'h04, 8'h1B, 1'b0};
        tbl[5] = '{K_BAD_SPACE, 32'h0,        1'b0, EV_ERR,  8'h04, 8'h1B, 1'b0};
        tbl[6] = '{K_SHORT_BIT, 32'h0,        1'b0, EV_ERR,  8'h04, 8'h1B, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_address", address, 0);
        check("rst_command", command, 0);
        check("rst_pulses", {repeat_pulse, error_pulse, overrun_pulse}, 0);
        reset = 1'b1;
        hold(1'b1, 20);

        for (int i = 0; i < 7; i++) begin
            expect_ev(tbl[i].ev, tbl[i].ea, tbl[i].ec);
            case (tbl[i].kind)
                K_FRAME: send_frame(tbl[i].word);
                K_REPEAT: begin
                    hold(1'b0, 9000);
                    hold(1'b1, 2250);
                    hold(1'b0, 450);
                    hold(1'b1, 200);
                end
                K_SHORT_LDR: begin
                    hold(1'b0, 5000);
                    hold(1'b1, 200);
                end
                K_BAD_SPACE: begin
                    hold(1'b0, 8100);
                    hold(1'b1, 3000);
                    hold(1'b0, 450);
                    hold(1'b1, 200);
                end
                default: begin
                    hold(1'b0, 8100);
                    hold(1'b1, 4100);
                    hold(1'b0, 300);
                    hold(1'b1, 200);
                end
            endcase
            drain($sformatf("vec%0d_drained", i));
            check($sformatf("vec%0d_fv", i), frame_valid, tbl[i].efv);
            check($sformatf("vec%0d_address", i), address, tbl[i].ea);
            check($sformatf("vec%0d_command", i), command, tbl[i].ec);
            if (tbl[i].do_ack) begin
                do_ack();
            end
        end

        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ack_idle_fv", frame_valid, 0);

        expect_ev(EV_ERR, 8'h00, 8'h00);
        ir_n = 1'b0;
        n = 0;
        while (!error_pulse && n < 13000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_in_window", (n >= 11995 && n <= 12010) ? 1 : 0, 1);
        hold(1'b0, 13000 - n);
        hold(1'b1, 200);
        drain("timeout_drained");

        hold(1'b0, 8100);
        hold(1'b1, 4100);
        send_bits(32'h3CC3AA55, 17);
        hold(1'b0, 200);
        reset = 1'b0;
        #1;
        check("midrst_fv", frame_valid, 0);
        check("midrst_address", address, 0);
        check("midrst_command", command, 0);
        check("midrst_pulses", {repeat_pulse, error_pulse, overrun_pulse}, 0);
        ir_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        hold(1'b1, 100);
        check("midrst_no_events", sb.size(), 0);

        expect_ev(EV_LOAD, 8'h55, 8'hC3);
        send_frame(32'h3CC3AA55);
        drain("final_drained");
        check("final_fv", frame_valid, 1);
        check("final_address", address, 8'h55);
        check("final_command", command, 8'hC3);
        do_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
